// File: rtl/snn_layer_tdm.sv
// Time-multiplexed fully-connected leaky integrate-and-fire layer.
// One shared accumulator walks every synapse of one neuron, then updates that
// neuron's membrane potential; a timestep costs N_OUT*(N_IN+1)+1 cycles.
module snn_layer_tdm #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned DW         = 16,
  parameter int unsigned WW         = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int          THRESH     = 256,
  parameter int unsigned REFRAC     = 2,
  localparam int unsigned NW        = N_IN * N_OUT,
  localparam int unsigned AW        = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 step_start,
  input  logic [N_IN-1:0]      in_spike,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_addr,
  input  logic signed [WW-1:0] wt_wdata,
  output logic                 busy,
  output logic                 step_done,
  output logic [N_OUT-1:0]     out_spike
);

  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned VXW = DW + 2;

  localparam logic signed [VXW-1:0] V_MAX = VXW'((2 ** (DW - 1)) - 1);
  localparam logic signed [VXW-1:0] V_MIN = -V_MAX - VXW'(1);
  localparam logic signed [DW-1:0]  THR   = DW'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

  state_t                 state_q, state_nx;
  logic [N_IN-1:0]        in_l_q;
  logic [IW-1:0]          i_q;
  logic [JW-1:0]          j_q;
  logic [AW-1:0]          widx_q;
  logic signed [VXW-1:0]  acc_q;
  logic signed [DW-1:0]   v_q   [N_OUT];
  logic [RW-1:0]          rf_q  [N_OUT];
  logic [N_OUT-1:0]       spk_q;
  logic signed [WW-1:0]   wt_q  [NW];

  logic signed [VXW-1:0]  w_sel_c;
  logic signed [DW-1:0]   v_cur_c;
  logic signed [VXW-1:0]  v_ext_c;
  logic signed [DW-1:0]   v_sat_c;
  logic                   fire_c;
  logic                   i_last_c;
  logic                   j_last_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nx;
  end

  // Next-state logic; en low freezes the sequence
  always_comb begin
    state_nx = state_q;
    if (en) begin
      case (state_q)
        S_IDLE:   if (step_start) state_nx = S_ACCUM;
        S_ACCUM:  if (i_last_c) state_nx = S_UPDATE;
        S_UPDATE: state_nx = j_last_c ? S_DONE : S_ACCUM;
        S_DONE:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Selected synapse weight and leaky/saturating membrane update for neuron j
  always_comb begin
    i_last_c = (i_q == IW'(N_IN - 1));
    j_last_c = (j_q == JW'(N_OUT - 1));
    w_sel_c  = VXW'(wt_q[widx_q]);
    v_cur_c  = v_q[j_q];
    v_ext_c  = VXW'(v_cur_c) - VXW'(v_cur_c >>> LEAK_SHIFT) + acc_q;
    if (v_ext_c > V_MAX)      v_sat_c = DW'(V_MAX);
    else if (v_ext_c < V_MIN) v_sat_c = DW'(V_MIN);
    else                      v_sat_c = DW'(v_ext_c);
    fire_c   = (v_sat_c >= THR);
  end

  // Weight array: writable only while idle and enabled, out-of-range dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NW; k++) wt_q[k] <= '0;
    end else if (en && (state_q == S_IDLE) && wt_we && (32'(wt_addr) < NW)) begin
      wt_q[wt_addr] <= wt_wdata;
    end
  end

  // Accumulate, neuron update and refractory bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_l_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      widx_q <= '0;
      acc_q  <= '0;
      spk_q  <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        v_q[k]  <= '0;
        rf_q[k] <= '0;
      end
    end else if (en) begin
      case (state_q)
        S_IDLE: begin
          if (step_start) begin
            in_l_q <= in_spike;
            i_q    <= '0;
            j_q    <= '0;
            widx_q <= '0;
            acc_q  <= '0;
          end
        end
        S_ACCUM: begin
          if (in_l_q[i_q]) acc_q <= acc_q + w_sel_c;
          i_q    <= i_q + IW'(1);
          widx_q <= widx_q + AW'(1);
        end
        S_UPDATE: begin
          if (rf_q[j_q] != '0) begin
            rf_q[j_q]  <= rf_q[j_q] - RW'(1);
            v_q[j_q]   <= '0;
            spk_q[j_q] <= 1'b0;
          end else if (fire_c) begin
            rf_q[j_q]  <= RW'(REFRAC);
            v_q[j_q]   <= '0;
            spk_q[j_q] <= 1'b1;
          end else begin
            v_q[j_q]   <= v_sat_c;
            spk_q[j_q] <= 1'b0;
          end
          acc_q <= '0;
          i_q   <= '0;
          j_q   <= j_q + JW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and spike outputs; step_done suppressed while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      step_done <= 1'b0;
      out_spike <= '0;
    end else if (en) begin
      busy      <= (state_nx != S_IDLE);
      step_done <= (state_q == S_DONE);
      if (state_q == S_DONE) out_spike <= spk_q;
    end else begin
      step_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_layer_tdm.sv
// Self-checking bench: two layer instances (DW=16 and DW=10) share stimulus
// and are compared against an arithmetic reference model of the layer.
module tb_snn_layer_tdm;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              step_start = 1'b0;
  logic              wt_we = 1'b0;
  logic [3:0]        in_spike = '0;
  logic [2:0]        wt_addr = '0;
  logic signed [7:0] wt_wdata = '0;
  logic              busy_a, done_a, busy_b, done_b;
  logic [1:0]        spk_a, spk_b;

  int checks = 0;
  int errors = 0;

  int         w_m [8];
  int         v_a [2];
  int         v_b [2];
  int         rf_a [2];
  int         rf_b [2];
  logic [1:0] exp_a, exp_b;

  typedef struct {
    logic [3:0] sp;
    logic [1:0] exp;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  snn_layer_tdm u_dut (
    .clk(clk), .rst(rst), .en(en), .step_start(step_start), .in_spike(in_spike),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata),
    .busy(busy_a), .step_done(done_a), .out_spike(spk_a)
  );

  snn_layer_tdm #(.DW(10)) u_sat (
    .clk(clk), .rst(rst), .en(en), .step_start(step_start), .in_spike(in_spike),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata),
    .busy(busy_b), .step_done(done_b), .out_spike(spk_b)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) w_m[k] = 0;
    for (int k = 0; k < 2; k++) begin
      v_a[k] = 0; v_b[k] = 0; rf_a[k] = 0; rf_b[k] = 0;
    end
    exp_a = '0;
    exp_b = '0;
  endtask

  // One LIF neuron per timestep for a given potential width
  task automatic neuron_step(input int dw, input int acc, inout int v, inout int rf, output bit s);
    int vn, hi, lo;
    hi = (1 <<< (dw - 1)) - 1;
    lo = -(1 <<< (dw - 1));
    s = 1'b0;
    if (rf > 0) begin
      rf = rf - 1;
      v  = 0;
    end else begin
      vn = v - (v >>> 3) + acc;
      if (vn > hi) vn = hi;
      if (vn < lo) vn = lo;
      if (vn >= 256) begin
        s = 1'b1; v = 0; rf = 2;
      end else begin
        v = vn;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] sp);
    int acc;
    bit s;
    for (int j = 0; j < 2; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) if (sp[i]) acc += w_m[j*4 + i];
      neuron_step(16, acc, v_a[j], rf_a[j], s);
      exp_a[j] = s;
      neuron_step(10, acc, v_b[j], rf_b[j], s);
      exp_b[j] = s;
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    en = 1'b1; wt_we = 1'b1; wt_addr = 3'(a); wt_wdata = 8'(d);
    @(negedge clk);
    wt_we = 1'b0;
    w_m[a] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Run one timestep; optional fixed stall window, random stalls, busy pokes
  task automatic run_step(input logic [3:0] sp, input int stall_from, input int stall_len,
                          input bit poke, input bit rnd_en, output int lat);
    int stalls, bad_busy;
    bit seen;
    @(negedge clk);
    en = 1'b1; in_spike = sp; step_start = 1'b1;
    @(posedge clk);
    #1;
    step_start = 1'b0;
    in_spike = 4'($urandom);
    model_step(sp);
    chk("busy_after_accept", int'(busy_a), 1);
    lat = 0; stalls = 0; bad_busy = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      en = 1'b1;
      if (lat + 1 >= stall_from && lat + 1 < stall_from + stall_len) en = 1'b0;
      if (rnd_en && $urandom_range(0, 3) == 0) en = 1'b0;
      step_start = poke && (lat + 1 == 3);
      wt_we = poke && (lat + 1 == 4);
      wt_addr = 3'd0;
      wt_wdata = -8'sd50;
      if (!en) stalls++;
      @(posedge clk);
      #1;
      lat++;
      if (done_a) seen = 1'b1;
      else if (!busy_a || done_b) bad_busy++;
    end
    step_start = 1'b0; wt_we = 1'b0; en = 1'b1;
    chk("done_seen", int'(seen), 1);
    chk("latency", lat, 11 + stalls);
    chk("busy_during_step", bad_busy, 0);
    chk("done_b_aligned", int'(done_b), 1);
    chk("busy_low_at_done", int'(busy_a), 0);
    chk("spk_a_model", int'(spk_a), int'(exp_a));
    chk("spk_b_model", int'(spk_b), int'(exp_b));
    @(posedge clk);
    #1;
    chk("done_single_pulse", int'(done_a), 0);
    chk("spk_a_stable", int'(spk_a), int'(exp_a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, bad, dcnt;
    model_reset();

    tbl[0] = '{4'b0011, 2'b00};
    tbl[1] = '{4'b0011, 2'b01};
    tbl[2] = '{4'b0011, 2'b00};
    tbl[3] = '{4'b0011, 2'b00};
    tbl[4] = '{4'b0011, 2'b00};
    tbl[5] = '{4'b0011, 2'b01};

    // Reset held with random inputs
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      en = 1'($urandom); step_start = 1'($urandom); wt_we = 1'($urandom);
      in_spike = 4'($urandom); wt_addr = 3'($urandom); wt_wdata = 8'($urandom);
      @(posedge clk);
      #1;
      if (busy_a || done_a || spk_a != 2'b00 || busy_b || done_b || spk_b != 2'b00) bad++;
    end
    chk("reset_outputs_zero", bad, 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_spk", int'(spk_a), 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; step_start = 1'b0; wt_we = 1'b0;

    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk("zero_weight_spk", int'(spk_a), 0);
    chk("first_latency", lat, 11);

    // Integrate, fire, leak and refractory via table
    wr(0, 100);
    wr(1, 100);
    for (int k = 0; k < 6; k++) begin
      run_step(tbl[k].sp, 0, 0, 1'b0, 1'b0, lat);
      chk("table_spk", int'(spk_a), int'(tbl[k].exp));
      chk("table_latency", lat, 11);
    end

    // Pokes while busy are ignored, stall of three cycles stretches latency
    run_step(4'b0011, 0, 0, 1'b1, 1'b0, lat);
    chk("poke_latency", lat, 11);
    run_step(4'b0011, 2, 3, 1'b0, 1'b0, lat);
    chk("stall_latency", lat, 14);
    run_step(4'b0011, 0, 0, 1'b0, 1'b0, lat);
    chk("post_poke_no_fire", int'(spk_a), 0);
    run_step(4'b0011, 0, 0, 1'b0, 1'b0, lat);
    chk("weight_kept_fire", int'(spk_a), 1);

    // Saturation: DW=10 clamps to -512, DW=16 does not
    pulse_reset();
    for (int k = 4; k < 8; k++) wr(k, -128);
    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk("neg_never_fires", int'(spk_b), 0);
    for (int k = 4; k < 8; k++) wr(k, 127);
    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk("sat_fire_dw10", int'(spk_b), 2);
    chk("nosat_dw16", int'(spk_a), 0);

    // Asynchronous reset mid-step
    @(negedge clk);
    en = 1'b1; in_spike = 4'b1111; step_start = 1'b1;
    @(posedge clk);
    #1;
    step_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy_a", int'(busy_a), 0);
    chk("async_busy_b", int'(busy_b), 0);
    chk("async_spk_b", int'(spk_b), 0);
    chk("async_done", int'(done_a), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done_a || done_b || busy_a) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);
    run_step(4'b1111, 0, 0, 1'b0, 1'b0, lat);
    chk("weights_cleared_a", int'(spk_a), 0);
    chk("weights_cleared_b", int'(spk_b), 0);

    // Randomized steps, weights and stalls against the model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 217)) - 90);
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 217)) - 90);
      end
      run_step(4'($urandom), 0, 0, 1'b0, 1'b1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
